// File: rtl/mem_word_port.sv
// mem_word_port: sequences 8/16-bit little-endian CPU accesses onto a byte-wide, registered-read memory.
// Optional macro MEM_WORD_PORT_ALIGN_CHECK_EN: fault unaligned word accesses instead of performing them.
module mem_word_port #(
  parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        err,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned AW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned DW = 2 * BW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER0,
    ST_XFER1,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            r_we;
  logic            r_word;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [BW-1:0]   r_rd_lo;
  logic [DW-1:0]   r_rdata;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_accept;
  logic            w_fault;
  logic            w_mem_wr;
  logic [AW-1:0]   w_mem_addr;
  logic [BW-1:0]   w_mem_wdata;

  assign w_accept = (r_state == ST_IDLE) && req;

`ifdef MEM_WORD_PORT_ALIGN_CHECK_EN
  assign w_fault = w_accept && word && addr[0];
`else
  assign w_fault = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and memory-side decode from registered state only
  always_comb begin
    w_next_state = r_state;
    w_mem_wr     = 1'b0;
    w_mem_addr   = IDLE_ADDR;
    w_mem_wdata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_fault) begin
          w_next_state = ST_DONE;
        end else if (req) begin
          w_next_state = ST_XFER0;
        end
      end
      ST_XFER0: begin
        w_mem_wr    = r_we;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata[BW-1:0];
        if (r_word) begin
          w_next_state = ST_XFER1;
        end else if (r_we) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_XFER1: begin
        w_mem_wr     = r_we;
        w_mem_addr   = AW'(r_addr + AW'(1));
        w_mem_wdata  = r_wdata[DW-1:BW];
        w_next_state = r_we ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Request latch, read assembly and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_word  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd_lo <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= (w_next_state == ST_DONE);
      r_err  <= w_fault;
      if (w_accept) begin
        r_we    <= we;
        r_word  <= word;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      // Low byte parks in a shadow so rdata only changes when a read completes
      if ((r_state == ST_XFER1) && !r_we) begin
        r_rd_lo <= mem_rdata;
      end
      if (r_state == ST_WAIT) begin
        r_rdata <= r_word ? {mem_rdata, r_rd_lo} : {BW'(0), mem_rdata};
      end
    end
  end

  // A reset landing mid-transfer must not let the in-flight byte commit
  assign mem_wr    = w_mem_wr & ~rst;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;

  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_word_port.sv
// Self-checking bench for mem_word_port: byte-memory model, transaction-level reference and scenario tasks.
module tb_mem_word_port;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic        word;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        err;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_cmp;
  int n_bad;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] ref_rdata;
  logic [15:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  logic [15:0] bz_a_q[$];
  logic [15:0] exp_a_q[$];
  logic [7:0]  exp_d_q[$];

  mem_word_port #(.IDLE_ADDR(16'hFFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .word      (word),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  function automatic logic [7:0] seed_byte(input int i);
    return 8'((i * 29) ^ (i >>> 5) ^ 32'h5A);
  endfunction

  // Byte memory with registered read; also logs every write and every busy-cycle address
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = seed_byte(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      mem_rdata <= mem[mem_addr];
      if (mem_wr === 1'b1) begin
        mem[mem_addr] = mem_wdata;
        wr_a_q.push_back(mem_addr);
        wr_d_q.push_back(mem_wdata);
      end
      if (busy === 1'b1) bz_a_q.push_back(mem_addr);
    end
  end

  // Transaction-level reference: latency, memory effect, read result, fault
  task automatic model_xfer(input logic m_we, input logic m_word, input logic [15:0] m_addr,
                            input logic [15:0] m_wdata, output int m_lat, output logic m_err);
    logic [15:0] a1;
    a1 = m_addr + 16'd1;
    exp_a_q.delete();
    exp_d_q.delete();
    m_err = 1'b0;
`ifdef MEM_WORD_PORT_ALIGN_CHECK_EN
    if (m_word && m_addr[0]) begin
      m_lat = 1;
      m_err = 1'b1;
      return;
    end
`endif
    m_lat = (m_word ? 3 : 2) + (m_we ? 0 : 1);
    if (m_we) begin
      ref_mem[m_addr] = m_wdata[7:0];
      exp_a_q.push_back(m_addr);
      exp_d_q.push_back(m_wdata[7:0]);
      if (m_word) begin
        ref_mem[a1] = m_wdata[15:8];
        exp_a_q.push_back(a1);
        exp_d_q.push_back(m_wdata[15:8]);
      end
    end else begin
      ref_rdata = m_word ? {ref_mem[a1], ref_mem[m_addr]} : {8'h00, ref_mem[m_addr]};
    end
  endtask

  // Issue one request and observe: cycles to done, rdata/err at done, busy up to done, idle cycle after
  task automatic do_xfer(input logic t_we, input logic t_word, input logic [15:0] t_addr,
                         input logic [15:0] t_wdata, output int lat, output logic [15:0] o_rd,
                         output logic o_err, output logic busy_ok, output logic p_busy,
                         output logic p_done);
    lat = 0;
    o_rd = '0;
    o_err = 1'b0;
    busy_ok = 1'b1;
    req = 1'b1;
    we = t_we;
    word = t_word;
    addr = t_addr;
    wdata = t_wdata;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) req = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        o_rd = rdata;
        o_err = err;
        break;
      end
    end
    @(negedge clk);
    p_busy = busy;
    p_done = done;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_addr !== 16'hFFFF) begin n_bad++; $display("FAIL idle_mem_addr: got %h expected ffff", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'h00) begin n_bad++; $display("FAIL idle_mem_wdata: got %h expected 00", mem_wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_byte_write_read();
    int lat, e_lat, base;
    logic [15:0] rd;
    logic er, e_er, bok, pb, pd;
    base = wr_a_q.size();
    model_xfer(1'b1, 1'b0, 16'h2010, 16'h00A5, e_lat, e_er);
    do_xfer(1'b1, 1'b0, 16'h2010, 16'h00A5, lat, rd, er, bok, pb, pd);
    n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL bw_latency: got %0d expected %0d", lat, e_lat); end
    n_cmp++; if (er !== e_er) begin n_bad++; $display("FAIL bw_err: got %b expected %b", er, e_er); end
    n_cmp++;
    if (wr_a_q.size() - base != 1) begin
      n_bad++; $display("FAIL bw_wr_count: got %0d expected 1", wr_a_q.size() - base);
    end else if (wr_a_q[base] !== 16'h2010 || wr_d_q[base] !== 8'hA5) begin
      n_bad++; $display("FAIL bw_wr_data: got %h/%h expected 2010/a5", wr_a_q[base], wr_d_q[base]);
    end
    n_cmp++; if (pb !== 1'b0 || pd !== 1'b0) begin n_bad++; $display("FAIL bw_post_idle: got busy=%b done=%b expected 0/0", pb, pd); end
    model_xfer(1'b0, 1'b0, 16'h2010, 16'h0000, e_lat, e_er);
    do_xfer(1'b0, 1'b0, 16'h2010, 16'h0000, lat, rd, er, bok, pb, pd);
    n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL br_latency: got %0d expected %0d", lat, e_lat); end
    n_cmp++; if (rd !== 16'h00A5) begin n_bad++; $display("FAIL br_rdata: got %h expected 00a5", rd); end
    n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL br_busy: got %b expected 1", bok); end
  endtask

  task automatic test_word_write_read();
    int lat, e_lat, base;
    logic [15:0] rd;
    logic er, e_er, bok, pb, pd;
    base = wr_a_q.size();
    model_xfer(1'b1, 1'b1, 16'h2020, 16'hBEEF, e_lat, e_er);
    do_xfer(1'b1, 1'b1, 16'h2020, 16'hBEEF, lat, rd, er, bok, pb, pd);
    n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL ww_latency: got %0d expected %0d", lat, e_lat); end
    n_cmp++;
    if (wr_a_q.size() - base != 2) begin
      n_bad++; $display("FAIL ww_wr_count: got %0d expected 2", wr_a_q.size() - base);
    end else if (wr_a_q[base] !== 16'h2020 || wr_d_q[base] !== 8'hEF ||
                 wr_a_q[base+1] !== 16'h2021 || wr_d_q[base+1] !== 8'hBE) begin
      n_bad++; $display("FAIL ww_wr_data: got %h/%h %h/%h expected 2020/ef 2021/be",
                        wr_a_q[base], wr_d_q[base], wr_a_q[base+1], wr_d_q[base+1]);
    end
    model_xfer(1'b0, 1'b1, 16'h2020, 16'h0000, e_lat, e_er);
    do_xfer(1'b0, 1'b1, 16'h2020, 16'h0000, lat, rd, er, bok, pb, pd);
    n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL wr_latency: got %0d expected %0d", lat, e_lat); end
    n_cmp++; if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL wr_rdata: got %h expected beef", rd); end
  endtask

  task automatic test_wrap();
    int lat, e_lat, bbase;
    logic [15:0] rd;
    logic er, e_er, bok, pb, pd;
    bbase = bz_a_q.size();
    model_xfer(1'b0, 1'b1, 16'hFFFF, 16'h0000, e_lat, e_er);
    do_xfer(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, rd, er, bok, pb, pd);
    n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL wrap_latency: got %0d expected %0d", lat, e_lat); end
    n_cmp++; if (er !== e_er) begin n_bad++; $display("FAIL wrap_err: got %b expected %b", er, e_er); end
`ifndef MEM_WORD_PORT_ALIGN_CHECK_EN
    n_cmp++;
    if (bz_a_q.size() < bbase + 2) begin
      n_bad++; $display("FAIL wrap_addr_count: got %0d expected >=2", bz_a_q.size() - bbase);
    end else if (bz_a_q[bbase] !== 16'hFFFF || bz_a_q[bbase+1] !== 16'h0000) begin
      n_bad++; $display("FAIL wrap_addr_seq: got %h,%h expected ffff,0000", bz_a_q[bbase], bz_a_q[bbase+1]);
    end
    n_cmp++; if (rd !== ref_rdata) begin n_bad++; $display("FAIL wrap_rdata: got %h expected %h", rd, ref_rdata); end
`endif
  endtask

  task automatic test_busy_reject();
    int lat, e_lat, lat2, base, bbase;
    logic e_er;
    logic [15:0] exp1;
    base = wr_a_q.size();
    bbase = bz_a_q.size();
    model_xfer(1'b0, 1'b1, 16'h2020, 16'h0000, e_lat, e_er);
    exp1 = ref_rdata;
    lat = 0;
    lat2 = 0;
    req = 1'b1; we = 1'b0; word = 1'b1; addr = 16'h2020; wdata = 16'h0000;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin word = 1'b0; addr = 16'h3000; end
      if (done === 1'b1) begin lat = n; break; end
    end
    n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL rej_latency: got %0d expected %0d", lat, e_lat); end
    n_cmp++; if (rdata !== exp1) begin n_bad++; $display("FAIL rej_rdata: got %h expected %h", rdata, exp1); end
    n_cmp++;
    if (bz_a_q.size() < bbase + 2) begin
      n_bad++; $display("FAIL rej_addr_count: got %0d expected >=2", bz_a_q.size() - bbase);
    end else if (bz_a_q[bbase] !== 16'h2020 || bz_a_q[bbase+1] !== 16'h2021) begin
      n_bad++; $display("FAIL rej_addr_seq: got %h,%h expected 2020,2021", bz_a_q[bbase], bz_a_q[bbase+1]);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rej_idle_gap: got busy=%b expected 0", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || mem_addr !== 16'h3000) begin
      n_bad++; $display("FAIL rej_next_accept: got busy=%b addr=%h expected 1/3000", busy, mem_addr);
    end
    req = 1'b0;
    model_xfer(1'b0, 1'b0, 16'h3000, 16'h0000, e_lat, e_er);
    for (int n = 2; n <= 8; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat2 = n; break; end
    end
    n_cmp++; if (lat2 !== e_lat) begin n_bad++; $display("FAIL rej2_latency: got %0d expected %0d", lat2, e_lat); end
    n_cmp++; if (rdata !== ref_rdata) begin n_bad++; $display("FAIL rej2_rdata: got %h expected %h", rdata, ref_rdata); end
    n_cmp++; if (wr_a_q.size() != base) begin n_bad++; $display("FAIL rej_no_write: got %0d writes expected 0", wr_a_q.size() - base); end
    @(negedge clk);
  endtask

  task automatic test_unaligned();
    int lat, e_lat, base;
    logic [15:0] rd;
    logic er, e_er, bok, pb, pd;
    base = wr_a_q.size();
    model_xfer(1'b1, 1'b1, 16'h2011, 16'hC3D4, e_lat, e_er);
    do_xfer(1'b1, 1'b1, 16'h2011, 16'hC3D4, lat, rd, er, bok, pb, pd);
    n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL ua_latency: got %0d expected %0d", lat, e_lat); end
    n_cmp++; if (er !== e_er) begin n_bad++; $display("FAIL ua_err: got %b expected %b", er, e_er); end
    n_cmp++;
    if (wr_a_q.size() - base != exp_a_q.size()) begin
      n_bad++; $display("FAIL ua_wr_count: got %0d expected %0d", wr_a_q.size() - base, exp_a_q.size());
    end else begin
      for (int j = 0; j < exp_a_q.size(); j++) begin
        if (wr_a_q[base+j] !== exp_a_q[j] || wr_d_q[base+j] !== exp_d_q[j]) begin
          n_bad++; $display("FAIL ua_wr_data: got %h/%h expected %h/%h", wr_a_q[base+j], wr_d_q[base+j], exp_a_q[j], exp_d_q[j]);
          break;
        end
      end
    end
    n_cmp++; if (pd !== 1'b0) begin n_bad++; $display("FAIL ua_done_width: got %b expected 0", pd); end
  endtask

  task automatic test_reset_mid();
    int base;
    logic saw_done;
    logic [7:0] keep_hi;
    base = wr_a_q.size();
    keep_hi = ref_mem[16'h2031];
    req = 1'b1; we = 1'b1; word = 1'b1; addr = 16'h2030; wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_mem[16'h2030] = 8'h34;
    ref_rdata = 16'h0000;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    n_cmp++; if (rdata !== ref_rdata) begin n_bad++; $display("FAIL rmid_rdata: got %h expected %h", rdata, ref_rdata); end
    saw_done = done;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rmid_no_done: got %b expected 0", saw_done); end
    n_cmp++; if (mem[16'h2030] !== 8'h34) begin n_bad++; $display("FAIL rmid_lo_byte: got %h expected 34", mem[16'h2030]); end
    n_cmp++; if (mem[16'h2031] !== keep_hi) begin n_bad++; $display("FAIL rmid_hi_byte: got %h expected %h", mem[16'h2031], keep_hi); end
    n_cmp++; if (wr_a_q.size() - base != 1) begin n_bad++; $display("FAIL rmid_wr_count: got %0d expected 1", wr_a_q.size() - base); end
  endtask

  task automatic test_random();
    int lat, e_lat, base;
    logic [15:0] rd, t_a, t_d;
    logic er, e_er, bok, pb, pd, t_we, t_word;
    for (int k = 0; k < 60; k++) begin
      t_we = 1'($urandom_range(0, 1));
      t_word = 1'($urandom_range(0, 1));
      t_a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'(16'h4000 + $urandom_range(0, 15));
      t_d = 16'($urandom);
      base = wr_a_q.size();
      model_xfer(t_we, t_word, t_a, t_d, e_lat, e_er);
      do_xfer(t_we, t_word, t_a, t_d, lat, rd, er, bok, pb, pd);
      n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL rnd_latency k=%0d we=%b word=%b addr=%h: got %0d expected %0d", k, t_we, t_word, t_a, lat, e_lat); end
      n_cmp++; if (rd !== ref_rdata) begin n_bad++; $display("FAIL rnd_rdata k=%0d addr=%h: got %h expected %h", k, t_a, rd, ref_rdata); end
      n_cmp++; if (er !== e_er) begin n_bad++; $display("FAIL rnd_err k=%0d: got %b expected %b", k, er, e_er); end
      n_cmp++; if (bok !== 1'b1 || pb !== 1'b0 || pd !== 1'b0) begin
        n_bad++; $display("FAIL rnd_handshake k=%0d: got busy_ok=%b post_busy=%b post_done=%b expected 1/0/0", k, bok, pb, pd);
      end
      n_cmp++;
      if (wr_a_q.size() - base != exp_a_q.size()) begin
        n_bad++; $display("FAIL rnd_wr_count k=%0d: got %0d expected %0d", k, wr_a_q.size() - base, exp_a_q.size());
      end else begin
        for (int j = 0; j < exp_a_q.size(); j++) begin
          if (wr_a_q[base+j] !== exp_a_q[j] || wr_d_q[base+j] !== exp_d_q[j]) begin
            n_bad++; $display("FAIL rnd_wr_data k=%0d: got %h/%h expected %h/%h", k, wr_a_q[base+j], wr_d_q[base+j], exp_a_q[j], exp_d_q[j]);
            break;
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req = 1'b0;
    we = 1'b0;
    word = 1'b0;
    addr = '0;
    wdata = '0;
    ref_rdata = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = seed_byte(i);
    test_reset();
    test_byte_write_read();
    test_word_write_read();
    test_wrap();
    test_busy_reject();
    test_unaligned();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_word_port.md
MEM_WORD_PORT -- requirements
Module: mem_word_port

Interface
REQ-001 SHALL have parameter IDLE_ADDR, default 16'hFFFF, the value driven on mem_addr when no transfer is active.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req  input  1  CPU request strobe; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 word  input  1  1 = 16-bit access, 0 = 8-bit access; sampled with req.
REQ-008 addr  input  16  byte address; sampled with req.
REQ-009 wdata  input  16  write data, little-endian; sampled with req.
REQ-010 busy  output  1  high from the cycle after acceptance through DONE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  16  read result; valid while done is high; held until the next read completes.
REQ-013 err  output  1  alignment fault flag, valid with done (config only; tied 0 otherwise).
REQ-014 mem_wr  output  1  byte-memory write enable.
REQ-015 mem_addr  output  16  byte-memory address.
REQ-016 mem_wdata  output  8  byte-memory write data.
REQ-017 mem_rdata  input  8  byte-memory read data; registered in memory, valid the cycle after its address is presented.

Function
REQ-018 SHALL implement FSM states IDLE, XFER0, XFER1, WAIT, DONE.
REQ-019 In IDLE with req=1, SHALL latch we, word, addr and wdata, and go to XFER0; req in any other state SHALL be ignored with no queueing.
REQ-020 XFER0 SHALL drive the following outputs, then go to XFER1 if word=1, otherwise to WAIT (read) or DONE (write):
- mem_addr = addr
- mem_wr = we
- mem_wdata = wdata[7:0]
REQ-021 XFER1 SHALL drive the following outputs, then go to WAIT (read) or DONE (write):
- mem_addr = addr+1, modulo 2^16 (16'hFFFF wraps to 16'h0000)
- mem_wr = we
- mem_wdata = wdata[15:8]
REQ-022 For a word read, SHALL capture mem_rdata into rdata[7:0] at the end of XFER1.
REQ-023 WAIT SHALL capture mem_rdata into rdata[15:8] for a word read; for a byte read it SHALL capture into rdata[7:0] with rdata[15:8]=0. WAIT always goes to DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, then go to IDLE; req is not accepted in DONE.
REQ-025 Outside XFER0/XFER1, mem_wr SHALL be 0, mem_addr SHALL be IDLE_ADDR, and mem_wdata SHALL be 0.
REQ-026 Latency from the req-accept edge to done high SHALL be:
- byte write: 2 cycles
- word write: 3 cycles
- byte read: 3 cycles
- word read: 4 cycles
REQ-027 A write SHALL leave rdata unchanged.
REQ-028 mem_* outputs SHALL be combinational decodes of registered state only; there is no combinational path from req/addr to mem_*.

Reset
REQ-029 While rst=1 at a rising edge, the state SHALL become IDLE and all of the following SHALL be 0: busy, done, err, rdata.
REQ-030 Reset mid-transfer SHALL abort with no done pulse; any byte already written stays written, and no further mem_wr is issued.
REQ-031 With the FSM in IDLE after reset, mem_wr SHALL be 0 and mem_addr SHALL be IDLE_ADDR.

Configuration
REQ-032 Macro MEM_WORD_PORT_ALIGN_CHECK_EN.
- Defined: a request with word=1 and addr[0]=1 SHALL go IDLE -> DONE directly, with no mem_wr and rdata unchanged. It SHALL assert err together with the done pulse; err is 0 otherwise.
- Undefined: unaligned word accesses SHALL proceed normally, and err SHALL be constant 0.

Verification
REQ-033 Byte write then byte read:
- write addr=16'h2010, wdata=16'h00A5, word=0.
- Expect: one mem_wr cycle at 16'h2010 with data 8'hA5; done 2 cycles after accept.
- Then read the same address: rdata=16'h00A5, done 3 cycles after accept.
REQ-034 Word write then word read:
- write addr=16'h2020, wdata=16'hBEEF.
- Expect: mem_wr at 16'h2020 with 8'hEF, then at 16'h2021 with 8'hBE.
- Then read: rdata=16'hBEEF, done 4 cycles after accept.
REQ-035 Wrap-around: word read at addr=16'hFFFF:
- Expect: mem_addr sequence 16'hFFFF then 16'h0000.
- rdata = {mem[0000], mem[FFFF]}.
REQ-036 Busy rejection: assert req with addr=16'h3000 on every cycle of a word read at 16'h2020.
- Expect: only the first request is performed.
- The next acceptance occurs on the first IDLE cycle after done.
REQ-037 Reset mid-transfer: assert rst during XFER1 of a word write to 16'h2030 with data 16'h1234.
- Expect: mem[2030]=8'h34 and mem[2031] unchanged.
- Expect: no done pulse; busy=0 the cycle after reset.
REQ-038 With MEM_WORD_PORT_ALIGN_CHECK_EN defined: word write at addr=16'h2011.
- Expect: no mem_wr; done and err high together 1 cycle after accept.
- Without the macro, the same access writes 16'h2011 and 16'h2012 and err stays 0.
